piso_tx: RTL and testbench

//   Parallel-in serial-out transmitter. It takes DATA_WIDTH-bit words through a valid/ready

---
 rtl/piso_tx_if.sv | 33 +++
 rtl/piso_tx.sv | 101 ++++++++++
 tb/tb_piso_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/piso_tx_if.sv
// Word-in / bit-out bundle of the serial transmitter.
// master: word source and line observer; slave: the transmitter itself.
interface piso_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  serial_out;
  logic                  out_valid;
  logic                  frame_start;
  logic                  busy;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  serial_out,
    input  out_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output serial_out,
    output out_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: first bit one cycle after accept, words back-to-back.
// Backpressure: in_ready only in IDLE or on the last bit; the source holds the word until then.
module piso_tx #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  piso_tx_if.slave bus
);
  localparam int              CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  serial_q;
  logic                  out_valid_q;
  logic                  frame_start_q;

  logic                  load_bit;
  logic [DATA_WIDTH-1:0] load_rest;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] next_rest;
  logic                  last_bit;

  // The bit on the line comes from serial_q; shreg holds only the bits still to go.
  always_comb begin
    load_bit  = 1'b0;
    load_rest = '0;
    next_bit  = 1'b0;
    next_rest = '0;
    if (MSB_FIRST) begin
      load_bit  = bus.in_data[DATA_WIDTH-1];
      load_rest = bus.in_data << 1;
      next_bit  = shreg[DATA_WIDTH-1];
      next_rest = shreg << 1;
    end else begin
      load_bit  = bus.in_data[0];
      load_rest = bus.in_data >> 1;
      next_bit  = shreg[0];
      next_rest = shreg >> 1;
    end
  end

  assign last_bit        = (state == SHIFT) && (cnt == LAST);
  assign bus.in_ready    = (state == IDLE) || last_bit;
  assign bus.serial_out  = serial_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state == SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      shreg         <= '0;
      serial_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state         <= SHIFT;
            cnt           <= '0;
            shreg         <= load_rest;
            serial_q      <= load_bit;
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            cnt           <= cnt + CW'(1);
            shreg         <= next_rest;
            serial_q      <= next_bit;
            frame_start_q <= 1'b0;
          end else if (bus.in_valid) begin
            // Reload on the last bit so the next word follows with no idle cycle.
            cnt           <= '0;
            shreg         <= load_rest;
            serial_q      <= load_bit;
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            state         <= IDLE;
            cnt           <= '0;
            shreg         <= '0;
            serial_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_piso_tx.sv
// Drives an MSB-first and an LSB-first transmitter with the same word stream and
// scores both serial lines against per-word bit lists built from each accepted word.
module tb_piso_tx;
  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  int checks = 0;
  int failures = 0;

  exp_t qm[$];
  exp_t ql[$];

  piso_tx_if #(.DATA_WIDTH(W)) ifm ();
  piso_tx_if #(.DATA_WIDTH(W)) ifl ();

  assign ifm.in_valid = in_valid;
  assign ifm.in_data  = in_data;
  assign ifl.in_valid = in_valid;
  assign ifl.in_data  = in_data;

  piso_tx #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (ifm.slave)
  );

  piso_tx #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (ifl.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // On every accepted word, queue the bits each line should carry, in wire order.
  always @(posedge clk) begin
    if (!reset && in_valid && ifm.in_ready) begin
      for (int i = 0; i < W; i++) begin
        qm.push_back('{b: in_data[W-1-i], fs: (i == 0)});
        ql.push_back('{b: in_data[i],     fs: (i == 0)});
      end
    end
  end

  task automatic check_lane(input string nm, input logic so, input logic ov,
                            input logic fs, input logic bsy, input logic rdy,
                            ref exp_t q[$]);
    exp_t e;
    if (ov === 1'b1) begin
      if (q.size() == 0) begin
        chk({nm, "_unexpected_bit"}, 32'(ov), 32'd0);
      end else begin
        e = q.pop_front();
        chk({nm, "_serial_out"}, 32'(so), 32'(e.b));
        chk({nm, "_frame_start"}, 32'(fs), 32'(e.fs));
      end
    end else begin
      chk({nm, "_out_valid"}, 32'(ov), 32'(q.size() != 0));
      chk({nm, "_idle_serial_out"}, 32'(so), 32'd0);
      chk({nm, "_idle_frame_start"}, 32'(fs), 32'd0);
    end
    chk({nm, "_busy"}, 32'(bsy), 32'(ov));
    // A new word may be taken only when no bits of the current one remain after this one.
    chk({nm, "_in_ready"}, 32'(rdy), 32'(q.size() == 0));
  endtask

  always @(negedge clk) begin
    check_lane("msb", ifm.serial_out, ifm.out_valid, ifm.frame_start, ifm.busy, ifm.in_ready, qm);
    check_lane("lsb", ifl.serial_out, ifl.out_valid, ifl.frame_start, ifl.busy, ifl.in_ready, ql);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and hold it until accepted; keep=1 leaves in_valid high for a follow-on word.
  task automatic send(input logic [W-1:0] d, input bit keep);
    int  budget = 0;
    bit  acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && budget < 64) begin
      @(negedge clk);
      acc = ifm.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout word %0h: not accepted within %0d cycles", d, budget);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    bit           keep;

    idle(3);
    reset = 1'b0;
    idle(2);

    // Single word then idle line
    send(8'hA5, 1'b0);
    idle(12);

    // Back-to-back pair, second taken on the last bit of the first
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b0);
    idle(12);

    // LSB-first lane sends 1 first, MSB-first lane sends it last
    send(8'h01, 1'b0);
    idle(10);

    // Stall: new word offered during bit 2 of an in-flight word
    send(8'h96, 1'b0);
    idle(2);
    send(8'hFF, 1'b0);
    idle(12);

    // Reset during bit 3 discards the word
    send(8'hC3, 1'b0);
    idle(3);
    reset = 1'b1;
    qm.delete();
    ql.delete();
    idle(2);
    reset = 1'b0;
    idle(1);
    send(8'h5A, 1'b0);
    idle(12);

    // Random words with random gaps or back-to-back continuation
    for (int n = 0; n < 40; n++) begin
      d    = W'($urandom);
      keep = ($urandom_range(0, 1) == 1);
      send(d, keep);
      if (!keep) idle($urandom_range(0, 3));
    end
    in_valid = 1'b0;
    idle(20);

    chk("msb_drained", 32'(qm.size()), 32'd0);
    chk("lsb_drained", 32'(ql.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
